// File: rtl/sa_cache_miss_ctrl_if.sv
// Bundle of the CPU port, sa_cache access port, backing-memory port and
// performance counters seen by the miss controller. The master modport is the
// controller's view; the slave modport is the view of whatever surrounds it.
interface sa_cache_miss_ctrl_if #(
    parameter int CNT_W = 16
);
    // CPU load/store port
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [31:0]       cpu_addr;
    logic              cpu_rw;
    logic [31:0]       cpu_wdata;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_rdata;
    logic              cpu_resp_err;

    // sa_cache access port
    logic [17:0]       c_tag;
    logic [7:0]        c_index;
    logic [5:0]        c_offset;
    logic [31:0]       c_dataW;
    logic              c_memRW;
    logic              c_req;
    logic [31:0]       c_data;
    logic              c_miss;
    logic              c_evict;
    logic [31:0]       c_evict_addr;
    logic [31:0]       c_evict_data;
    logic [31:0]       c_mem_line;
    logic              c_mem_response;

    // Single-beat backing-memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [31:0]       mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    // Performance counters
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  cpu_req_valid, cpu_addr, cpu_rw, cpu_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_resp_err,
        output c_tag, c_index, c_offset, c_dataW, c_memRW, c_req,
        input  c_data, c_miss, c_evict, c_evict_addr, c_evict_data,
        output c_mem_line, c_mem_response,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output hit_count, miss_count
    );

    modport slave (
        output cpu_req_valid, cpu_addr, cpu_rw, cpu_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata, cpu_resp_err,
        input  c_tag, c_index, c_offset, c_dataW, c_memRW, c_req,
        output c_data, c_miss, c_evict, c_evict_addr, c_evict_data,
        input  c_mem_line, c_mem_response,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/sa_cache_miss_ctrl.sv
// Request sequencer between one CPU load/store port, the 4-way sa_cache and a
// single-beat backing memory. One request is in flight at a time: it is looked
// up, and on a miss the dirty victim (if any) is written back, the line is
// refilled and the lookup replayed. A request that keeps missing after
// MAX_REPLAY refills is answered with an error. Every output is a register
// loaded on the transition into the state that owns it, so nothing the cache,
// memory or CPU sees is decoded combinationally from the state.
module sa_cache_miss_ctrl #(
    parameter int MAX_REPLAY = 2,
    parameter int CNT_W      = 16
) (
    input logic                   clk,
    input logic                   rst,
    sa_cache_miss_ctrl_if.master  bus
);

    localparam int RW = (MAX_REPLAY < 1) ? 1 : $clog2(MAX_REPLAY + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL_REQ,
        REFILL_WAIT,
        FILL,
        RESP
    } state_t;

    state_t         state;
    logic [RW-1:0]  replay_cnt;

    // Sequencer state, request latch, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state               <= IDLE;
            replay_cnt          <= '0;
            bus.cpu_req_ready   <= 1'b1;
            bus.cpu_resp_valid  <= 1'b0;
            bus.cpu_rdata       <= '0;
            bus.cpu_resp_err    <= 1'b0;
            bus.c_tag           <= '0;
            bus.c_index         <= '0;
            bus.c_offset        <= '0;
            bus.c_dataW         <= '0;
            bus.c_memRW         <= 1'b0;
            bus.c_req           <= 1'b0;
            bus.c_mem_line      <= '0;
            bus.c_mem_response  <= 1'b0;
            bus.mem_req_valid   <= 1'b0;
            bus.mem_req_we      <= 1'b0;
            bus.mem_req_addr    <= '0;
            bus.mem_req_wdata   <= '0;
            bus.hit_count       <= '0;
            bus.miss_count      <= '0;
        end else begin
            // Single-cycle pulses fall back to idle unless a transition below
            // re-asserts them.
            bus.cpu_resp_valid <= 1'b0;
            bus.c_mem_response <= 1'b0;
            bus.c_mem_line     <= '0;

            case (state)
                IDLE: begin
                    if (bus.cpu_req_valid && bus.cpu_req_ready) begin
                        // The c_* fields double as the request latch and stay
                        // put until the next request is accepted.
                        bus.c_tag         <= bus.cpu_addr[31:14];
                        bus.c_index       <= bus.cpu_addr[13:6];
                        bus.c_offset      <= bus.cpu_addr[5:0];
                        bus.c_dataW       <= bus.cpu_wdata;
                        bus.c_memRW       <= bus.cpu_rw;
                        replay_cnt        <= '0;
                        bus.cpu_req_ready <= 1'b0;
                        bus.c_req         <= 1'b1;
                        state             <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    bus.c_req <= 1'b0;
                    if (!bus.c_miss) begin
                        // Hits after a refill are the tail of a miss and are
                        // not counted as hits.
                        if ((replay_cnt == '0) && (bus.hit_count != {CNT_W{1'b1}})) begin
                            bus.hit_count <= bus.hit_count + CNT_W'(1);
                        end
                        bus.cpu_rdata      <= bus.c_memRW ? 32'h0 : bus.c_data;
                        bus.cpu_resp_err   <= 1'b0;
                        bus.cpu_resp_valid <= 1'b1;
                        state              <= RESP;
                    end else begin
                        if ((replay_cnt == '0) && (bus.miss_count != {CNT_W{1'b1}})) begin
                            bus.miss_count <= bus.miss_count + CNT_W'(1);
                        end
                        if (replay_cnt == RW'(MAX_REPLAY)) begin
                            bus.cpu_rdata      <= 32'h0;
                            bus.cpu_resp_err   <= 1'b1;
                            bus.cpu_resp_valid <= 1'b1;
                            state              <= RESP;
                        end else if (bus.c_evict) begin
                            // The memory request registers hold the victim
                            // until the write-back is accepted.
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_we    <= 1'b1;
                            bus.mem_req_addr  <= bus.c_evict_addr;
                            bus.mem_req_wdata <= bus.c_evict_data;
                            state             <= WB;
                        end else begin
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_we    <= 1'b0;
                            bus.mem_req_addr  <= {bus.c_tag, bus.c_index, 6'b0};
                            bus.mem_req_wdata <= 32'h0;
                            state             <= REFILL_REQ;
                        end
                    end
                end

                WB: begin
                    if (bus.mem_req_ready) begin
                        // Write-back accepted; reuse the channel for the refill
                        // read with no idle cycle in between.
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_req_we    <= 1'b0;
                        bus.mem_req_addr  <= {bus.c_tag, bus.c_index, 6'b0};
                        bus.mem_req_wdata <= 32'h0;
                        state             <= REFILL_REQ;
                    end
                end

                REFILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        bus.mem_req_we    <= 1'b0;
                        bus.mem_req_addr  <= 32'h0;
                        bus.mem_req_wdata <= 32'h0;
                        state             <= REFILL_WAIT;
                    end
                end

                REFILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        bus.c_mem_line     <= bus.mem_resp_data;
                        bus.c_mem_response <= 1'b1;
                        state              <= FILL;
                    end
                end

                FILL: begin
                    replay_cnt <= replay_cnt + RW'(1);
                    bus.c_req  <= 1'b1;
                    state      <= LOOKUP;
                end

                RESP: begin
                    bus.cpu_rdata     <= 32'h0;
                    bus.cpu_resp_err  <= 1'b0;
                    bus.cpu_req_ready <= 1'b1;
                    state             <= IDLE;
                end

                default: begin
                    bus.c_req          <= 1'b0;
                    bus.mem_req_valid  <= 1'b0;
                    bus.cpu_req_ready  <= 1'b1;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Self-checking bench for sa_cache_miss_ctrl. The bench plays the CPU, the
// cache and the backing memory; inputs change on the falling edge and outputs
// are sampled there too. A narrow counter width keeps the saturation run short.
module tb_sa_cache_miss_ctrl;

    localparam int          MAX_REPLAY = 2;
    localparam int          TB_CNT_W   = 10;
    localparam logic [31:0] CNT_MAX    = (32'd1 << TB_CNT_W) - 32'd1;

    typedef struct {
        logic [31:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic        miss;
        logic        always_miss;
        logic        evict;
        logic [31:0] evict_addr;
        logic [31:0] evict_data;
        logic [31:0] cdata;
        logic [31:0] mdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_hits   = 0;
    int   model_misses = 0;
    exp_t sb[$];
    vec_t tbl[8];

    sa_cache_miss_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    sa_cache_miss_ctrl #(
        .MAX_REPLAY (MAX_REPLAY),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_idle_inputs();
        bus.cpu_req_valid  = 1'b0;
        bus.cpu_addr       = 32'h0;
        bus.cpu_rw         = 1'b0;
        bus.cpu_wdata      = 32'h0;
        bus.c_data         = 32'h0;
        bus.c_miss         = 1'b0;
        bus.c_evict        = 1'b0;
        bus.c_evict_addr   = 32'h0;
        bus.c_evict_data   = 32'h0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
    endtask

    task automatic randomize_inputs();
        bus.cpu_req_valid  = 1'($urandom());
        bus.cpu_addr       = $urandom();
        bus.cpu_rw         = 1'($urandom());
        bus.cpu_wdata      = $urandom();
        bus.c_data         = $urandom();
        bus.c_miss         = 1'($urandom());
        bus.c_evict        = 1'($urandom());
        bus.c_evict_addr   = $urandom();
        bus.c_evict_data   = $urandom();
        bus.mem_req_ready  = 1'($urandom());
        bus.mem_resp_valid = 1'($urandom());
        bus.mem_resp_data  = $urandom();
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 10 && !bus.cpu_req_ready; w++) @(negedge clk);
        checkOutput("req_ready_idle", 32'(bus.cpu_req_ready), 32'd1);
    endtask

    // One full CPU transaction with the bench acting as cache and memory.
    task automatic applyStimulus(input vec_t v);
        exp_t     e;
        exp_t     got;
        mem_rec_t memq[$];
        int       refills, lookups, fills, stall_left, n_reads, n_writes;
        bit       resp_pending, prev_stalled, done;
        logic [31:0] prev_addr, prev_wdata;
        logic        prev_we;

        refills      = v.miss ? (v.always_miss ? MAX_REPLAY : 1) : 0;
        e.rdata      = v.exp_rdata;
        e.err        = v.exp_err;
        e.lat        = 2 + refills * 4 + ((v.miss && v.evict) ? 1 + v.stall : 0);
        lookups      = 0;
        fills        = 0;
        stall_left   = v.stall;
        resp_pending = 0;
        prev_stalled = 0;
        prev_addr    = 32'h0;
        prev_wdata   = 32'h0;
        prev_we      = 1'b0;
        done         = 0;

        wait_idle();
        sb.push_back(e);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = v.addr;
        bus.cpu_rw        = v.rw;
        bus.cpu_wdata     = v.wdata;
        @(posedge clk);

        for (int k = 1; k <= 200 && !done; k++) begin
            @(negedge clk);
            bus.cpu_req_valid  = 1'b0;
            bus.mem_resp_valid = resp_pending;
            bus.mem_resp_data  = resp_pending ? v.mdata : 32'h0;
            resp_pending       = 0;

            bus.c_miss       = 1'b0;
            bus.c_evict      = 1'b0;
            bus.c_evict_addr = 32'h0;
            bus.c_evict_data = 32'h0;
            bus.c_data       = v.cdata;
            if (bus.c_req) begin
                lookups++;
                checkOutput("c_addr_fields", {bus.c_tag, bus.c_index, bus.c_offset}, v.addr);
                checkOutput("c_dataW", bus.c_dataW, v.wdata);
                checkOutput("c_memRW", 32'(bus.c_memRW), 32'(v.rw));
                if (v.always_miss || (v.miss && lookups == 1)) begin
                    bus.c_miss = 1'b1;
                    if (v.evict && lookups == 1) begin
                        bus.c_evict      = 1'b1;
                        bus.c_evict_addr = v.evict_addr;
                        bus.c_evict_data = v.evict_data;
                    end
                end
            end

            if (bus.mem_req_valid) begin
                if (prev_stalled) begin
                    checkOutput("mem_hold_addr", bus.mem_req_addr, prev_addr);
                    checkOutput("mem_hold_wdata", bus.mem_req_wdata, prev_wdata);
                    checkOutput("mem_hold_we", 32'(bus.mem_req_we), 32'(prev_we));
                end
                prev_addr  = bus.mem_req_addr;
                prev_wdata = bus.mem_req_wdata;
                prev_we    = bus.mem_req_we;
                if (stall_left > 0) begin
                    bus.mem_req_ready = 1'b0;
                    stall_left--;
                    prev_stalled = 1;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    prev_stalled = 0;
                    memq.push_back('{bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata});
                    if (!bus.mem_req_we) resp_pending = 1;
                end
            end else begin
                bus.mem_req_ready = 1'b0;
                prev_stalled = 0;
            end

            if (bus.c_mem_response) begin
                fills++;
                checkOutput("fill_line", bus.c_mem_line, v.mdata);
            end

            if (bus.cpu_resp_valid) begin
                got = sb.pop_front();
                checkOutput("cpu_rdata", bus.cpu_rdata, got.rdata);
                checkOutput("cpu_resp_err", 32'(bus.cpu_resp_err), 32'(got.err));
                checkOutput("resp_latency", 32'(k), 32'(got.lat));
                checkOutput("ready_low_in_resp", 32'(bus.cpu_req_ready), 32'd0);
                done = 1;
            end
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;

        if (!done) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) got = sb.pop_front();
        end

        if (v.miss) begin
            if (model_misses < int'(CNT_MAX)) model_misses++;
        end else begin
            if (model_hits < int'(CNT_MAX)) model_hits++;
        end
        checkOutput("hit_count", 32'(bus.hit_count), 32'(model_hits));
        checkOutput("miss_count", 32'(bus.miss_count), 32'(model_misses));

        n_reads  = 0;
        n_writes = 0;
        foreach (memq[i]) begin
            if (memq[i].we) begin
                n_writes++;
                checkOutput("wb_addr", memq[i].addr, v.evict_addr);
                checkOutput("wb_data", memq[i].wdata, v.evict_data);
            end else begin
                n_reads++;
                checkOutput("refill_addr", memq[i].addr, {v.addr[31:6], 6'b0});
                checkOutput("refill_wdata", memq[i].wdata, 32'h0);
            end
        end
        checkOutput("refill_reads", 32'(n_reads), 32'(refills));
        checkOutput("fill_pulses", 32'(fills), 32'(refills));
        checkOutput("wb_writes", 32'((v.miss && v.evict) ? 1 : 0), 32'(n_writes));
        if (v.miss && v.evict && memq.size() >= 2) begin
            checkOutput("wb_before_read", {31'd0, memq[0].we, 1'b0} | {31'd0, memq[1].we}, 32'd2);
        end
    endtask

    // CPU holds valid across the first response; the second request may only
    // be taken in the IDLE cycle after RESP.
    task automatic run_back_to_back();
        int acc, nresp, a1, a2, r1, r2;
        bit drop;
        acc = 0; nresp = 0; a1 = -1; a2 = -1; r1 = -1; r2 = -1; drop = 0;
        wait_idle();
        bus.c_miss        = 1'b0;
        bus.c_evict       = 1'b0;
        bus.c_data        = 32'h600D_CAFE;
        bus.mem_req_ready = 1'b0;
        bus.cpu_addr      = 32'h0000_1100;
        bus.cpu_rw        = 1'b0;
        bus.cpu_req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (drop) bus.cpu_req_valid = 1'b0;
            if (bus.cpu_req_valid && bus.cpu_req_ready) begin
                acc++;
                if (acc == 1) a1 = k;
                else if (acc == 2) begin
                    a2 = k;
                    drop = 1;
                end
            end
            if (bus.cpu_resp_valid) begin
                nresp++;
                if (nresp == 1) r1 = k;
                else r2 = k;
                checkOutput("b2b_rdata", bus.cpu_rdata, 32'h600D_CAFE);
            end
            @(negedge clk);
        end
        bus.cpu_req_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(acc), 32'd2);
        checkOutput("b2b_first_accept", 32'(a1), 32'd0);
        checkOutput("b2b_second_accept", 32'(a2), 32'd3);
        checkOutput("b2b_responses", 32'(nresp), 32'd2);
        checkOutput("b2b_first_resp", 32'(r1), 32'd2);
        checkOutput("b2b_second_resp", 32'(r2), 32'd5);
        model_hits = (model_hits + 2 > int'(CNT_MAX)) ? int'(CNT_MAX) : model_hits + 2;
        checkOutput("b2b_hit_count", 32'(bus.hit_count), 32'(model_hits));
    endtask

    // Reset lands while the refill read is outstanding; the late memory
    // response must not revive the abandoned request.
    task automatic run_reset_mid_refill();
        bit reached, seen_read;
        int n_resp, n_fill, n_memreq, n_not_ready;
        reached = 0; seen_read = 0;
        n_resp = 0; n_fill = 0; n_memreq = 0; n_not_ready = 0;
        wait_idle();
        bus.cpu_addr      = 32'h2000_0100;
        bus.cpu_rw        = 1'b0;
        bus.cpu_req_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20 && !reached; k++) begin
            @(negedge clk);
            bus.cpu_req_valid = 1'b0;
            bus.c_miss        = bus.c_req;
            bus.c_evict       = 1'b0;
            if (seen_read) reached = 1;
            else if (bus.mem_req_valid) begin
                bus.mem_req_ready = 1'b1;
                seen_read = 1;
            end else bus.mem_req_ready = 1'b0;
        end
        checkOutput("rst_reached_wait", 32'(reached), 32'd1);
        bus.mem_req_ready = 1'b0;
        bus.c_miss        = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("rst_cpu_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        checkOutput("rst_cpu_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
        checkOutput("rst_miss_count", 32'(bus.miss_count), 32'd0);
        rst = 1'b1;
        model_hits   = 0;
        model_misses = 0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hBAD0_BAD0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            if (bus.cpu_resp_valid) n_resp++;
            if (bus.c_mem_response) n_fill++;
            if (bus.mem_req_valid) n_memreq++;
            if (!bus.cpu_req_ready) n_not_ready++;
        end
        checkOutput("late_resp_cpu_resp", 32'(n_resp), 32'd0);
        checkOutput("late_resp_fill", 32'(n_fill), 32'd0);
        checkOutput("late_resp_mem_req", 32'(n_memreq), 32'd0);
        checkOutput("late_resp_ready", 32'(n_not_ready), 32'd0);
    endtask

    initial begin
        vec_t hit_vec;

        //        addr          rw    wdata         miss  always evict evict_addr    evict_data    cdata         mdata         stall exp_rdata     exp_err
        tbl[0] = '{32'h0000_0040, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0};
        tbl[2] = '{32'h0000_9A04, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_8000, 32'h55AA_55AA, 32'h1111_2222, 32'h0BAD_C0DE, 3, 32'h1111_2222, 1'b0};
        tbl[3] = '{32'hFFFF_FFFC, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h9999_9999, 32'h0000_0000, 0, 32'h0000_0000, 1'b0};
        tbl[4] = '{32'h0040_0080, 1'b1, 32'h0102_0304, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1357_2468, 0, 32'h0000_0000, 1'b0};
        tbl[5] = '{32'h00AB_CDEF, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h7777_7777, 32'h2468_2468, 0, 32'h0000_0000, 1'b1};
        tbl[6] = '{32'h8765_4321, 1'b1, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b1, 32'h1000_0040, 32'hFEED_FACE, 32'h0000_0000, 32'h3141_5926, 1, 32'h0000_0000, 1'b1};
        tbl[7] = '{32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h3C3C_3C3C, 32'h0000_0000, 0, 32'h3C3C_3C3C, 1'b0};

        hit_vec = '{32'h0000_2A40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1234_ABCD, 32'h0, 0, 32'h1234_ABCD, 1'b0};

        $display("[TB] reset with random inputs");
        rst = 1'b0;
        randomize_inputs();
        @(posedge clk);
        @(negedge clk);
        randomize_inputs();
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_cpu_req_ready", 32'(bus.cpu_req_ready), 32'd1);
        checkOutput("reset_cpu_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
        checkOutput("reset_cpu_rdata", bus.cpu_rdata, 32'd0);
        checkOutput("reset_cpu_resp_err", 32'(bus.cpu_resp_err), 32'd0);
        checkOutput("reset_c_req", 32'(bus.c_req), 32'd0);
        checkOutput("reset_c_fields", {bus.c_tag, bus.c_index, bus.c_offset}, 32'd0);
        checkOutput("reset_c_dataW", bus.c_dataW, 32'd0);
        checkOutput("reset_c_mem_response", 32'(bus.c_mem_response), 32'd0);
        checkOutput("reset_c_mem_line", bus.c_mem_line, 32'd0);
        checkOutput("reset_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("reset_mem_req_addr", bus.mem_req_addr, 32'd0);
        checkOutput("reset_hit_count", 32'(bus.hit_count), 32'd0);
        checkOutput("reset_miss_count", 32'(bus.miss_count), 32'd0);
        set_idle_inputs();
        rst = 1'b1;

        $display("[TB] table-driven transactions");
        for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

        $display("[TB] back-to-back requests with valid held high");
        run_back_to_back();

        $display("[TB] reset during refill wait");
        run_reset_mid_refill();

        $display("[TB] hit counter saturation");
        for (int i = 0; i < (1 << TB_CNT_W) + 3; i++) applyStimulus(hit_vec);
        checkOutput("hit_count_saturated", 32'(bus.hit_count), CNT_MAX);
        checkOutput("miss_count_after_sat", 32'(bus.miss_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
